// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//   rxd -> 2-flop synchroniser -> fractional baud tick generator ->
//   3-sample majority vote at mid-bit -> frame FSM -> single-entry
//   valid/ready holding register with framing/parity/break/overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit after the
// data bits, checked against PARITY_ODD). Undefined: no parity bit and
// parity_err is tied low.
module uart_rx_param #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [31:0]    INC       = 32'(BAUD * OVERSAMPLE);
    localparam logic [31:0]    CLK_Q     = 32'(CLK_FREQ);
    localparam logic [CW-1:0]  SAMP0     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  SAMP1     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0]  BITPT     = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_rx_param: OVERSAMPLE must be a power of 2 in 8..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end
    if (BAUD * OVERSAMPLE > CLK_FREQ) begin : g_bad_rate
        $error("uart_rx_param: BAUD*OVERSAMPLE must not exceed CLK_FREQ");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          acc, acc_sum;
    logic                 tick;
    logic                 rx_meta, rs;
    logic [CW-1:0]        cnt;
    logic                 samp0, samp1, maj, bit_point;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 stop_bad, line_seen_high;
    logic                 frame_done, stop_ok, is_break, frame_good;

    // Fractional tick: one tick per OVERSAMPLE-th of a bit on average.
    assign acc_sum = acc + INC;
    assign tick    = (acc_sum >= CLK_Q);

    // Free-running phase accumulator for the oversample tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) acc <= '0;
        else     acc <= tick ? (acc_sum - CLK_Q) : acc_sum;
    end

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rs      <= rx_meta;
        end
    end

    // Majority of the samples at H-1, H and the live sample at H+1.
    assign maj       = (samp0 & samp1) | (samp0 & rs) | (samp1 & rs);
    assign bit_point = tick && (cnt == BITPT) && (state_q != S_IDLE);

    // Frame result evaluated on the final stop bit point.
    assign stop_ok  = !stop_bad && maj;
    assign is_break = (shreg == '0) && !stop_ok;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; frame_done marks the last stop bit point.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE:  if (!rs && line_seen_high) state_d = S_START;
            S_START: if (bit_point) state_d = maj ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_point && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_point) state_d = S_STOP;
`endif
            S_STOP: begin
                if (bit_point && bit_cnt == LAST_STOP) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timing, sampling, shift register and stop-bit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            samp0          <= 1'b1;
            samp1          <= 1'b1;
            shreg          <= '0;
            bit_cnt        <= '0;
            stop_bad       <= 1'b0;
            line_seen_high <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                cnt <= '0;
                if (rs) line_seen_high <= 1'b1;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
                if (cnt == SAMP0) samp0 <= rs;
                if (cnt == SAMP1) samp1 <= rs;
            end
            if (bit_point) begin
                case (state_q)
                    S_START: begin
                        bit_cnt  <= '0;
                        stop_bad <= 1'b0;
                    end
                    S_DATA: begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    S_STOP: begin
                        stop_bad <= stop_bad | !maj;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
            // A broken stop bit means the line may still be low: wait for idle.
            if (frame_done && !stop_ok) line_seen_high <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, parity_err_q;

    // Parity check at the parity bit point; pulse on completion unless break.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (bit_point && state_q == S_START) par_bad <= 1'b0;
            if (bit_point && state_q == S_PARITY)
                par_bad <= ((^shreg) ^ maj) != (PARITY_ODD != 0);
            parity_err_q <= frame_done && !is_break && par_bad;
        end
    end

    assign parity_err = parity_err_q;
    assign frame_good = stop_ok && !par_bad;
`else
    assign parity_err = 1'b0;
    assign frame_good = stop_ok;
`endif

    // Holding register and error pulses, updated the clk after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (frame_done) begin
                if (is_break) begin
                    break_det <= 1'b1;
                end else begin
                    if (!stop_ok) frame_err <= 1'b1;
                    if (frame_good) begin
                        if (!rx_valid || rx_ready) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
